// File: rtl/alu_pkg.sv
// Shared ALU ctrl codes, ALUOp and funct encodings.
// Used by the issue stage and the downstream ALU.
package alu_pkg;

  localparam logic [3:0] CTRL_AND = 4'd0;
  localparam logic [3:0] CTRL_OR  = 4'd1;
  localparam logic [3:0] CTRL_ADD = 4'd2;
  localparam logic [3:0] CTRL_MUL = 4'd3;
  localparam logic [3:0] CTRL_SUB = 4'd6;
  localparam logic [3:0] CTRL_SLT = 4'd7;
  localparam logic [3:0] CTRL_NOR = 4'd12;
  localparam logic [3:0] CTRL_ILL = 4'd15;

  localparam logic [2:0] OP_ADD   = 3'b000;
  localparam logic [2:0] OP_SUB   = 3'b001;
  localparam logic [2:0] OP_RTYPE = 3'b010;
  localparam logic [2:0] OP_SLT   = 3'b011;
  localparam logic [2:0] OP_OR    = 3'b100;
  localparam logic [2:0] OP_AND   = 3'b101;

  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2A;
  localparam logic [5:0] FN_MUL  = 6'h18;

endpackage

// File: rtl/alu_op_enc.sv
// Combinational ALUOp/funct -> ALU ctrl encoder.
// Ports: aluop_i, funct_i in; ctrl_o, illegal_o out.
module alu_op_enc
  import alu_pkg::*;
(
  input  logic [2:0] aluop_i,
  input  logic [5:0] funct_i,
  output logic [3:0] ctrl_o,
  output logic       illegal_o
);

  always_comb begin
    ctrl_o = CTRL_ILL;
    unique case (aluop_i)
      OP_ADD: ctrl_o = CTRL_ADD;
      OP_SUB: ctrl_o = CTRL_SUB;
      OP_SLT: ctrl_o = CTRL_SLT;
      OP_OR:  ctrl_o = CTRL_OR;
      OP_AND: ctrl_o = CTRL_AND;
      OP_RTYPE: begin
        unique case (funct_i)
          FN_ADD, FN_ADDU: ctrl_o = CTRL_ADD;
          FN_SUB, FN_SUBU: ctrl_o = CTRL_SUB;
          FN_AND:  ctrl_o = CTRL_AND;
          FN_OR:   ctrl_o = CTRL_OR;
          FN_NOR:  ctrl_o = CTRL_NOR;
          FN_SLT:  ctrl_o = CTRL_SLT;
          FN_MUL:  ctrl_o = CTRL_MUL;
          default: ctrl_o = CTRL_ILL;
        endcase
      end
      default: ctrl_o = CTRL_ILL;
    endcase
  end

  // No legal op maps to the ILL code.
  assign illegal_o = (ctrl_o == CTRL_ILL);

endmodule

// File: rtl/alu_op_issue.sv
// ALU issue stage: encode, buffer in a FIFO, hand to ALU.
// Ports: in_* upstream handshake, alu_* / ctrl/src downstream.
module alu_op_issue
  import alu_pkg::*;
#(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned DEPTH   = 2,
  parameter int unsigned MUL_LAT = 3
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       in_valid_i,
  output logic                       in_ready_o,
  input  logic [2:0]                 aluop_i,
  input  logic [5:0]                 funct_i,
  input  logic [DATA_W-1:0]          src1_i,
  input  logic [DATA_W-1:0]          src2_i,
  output logic                       alu_valid_o,
  input  logic                       alu_ready_i,
  output logic [3:0]                 ctrl_o,
  output logic [DATA_W-1:0]          src1_o,
  output logic [DATA_W-1:0]          src2_o,
  output logic                       illegal_o,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int MW = $clog2(MUL_LAT) + 1;

  logic [3:0]        ctrl_q [DEPTH];
  logic [DATA_W-1:0] s1_q   [DEPTH];
  logic [DATA_W-1:0] s2_q   [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [CW-1:0]     count_q;
  logic [MW-1:0]     mul_cnt;
  logic [3:0]        last_ctrl;
  logic [DATA_W-1:0] last_s1;
  logic [DATA_W-1:0] last_s2;

  logic [3:0] enc_ctrl;
  logic       enc_ill;
  logic       empty;
  logic       push;
  logic       pop;
  logic       head_mul;
  logic       settled;

  alu_op_enc u_enc (
    .aluop_i   (aluop_i),
    .funct_i   (funct_i),
    .ctrl_o    (enc_ctrl),
    .illegal_o (enc_ill)
  );

  assign empty      = (count_q == '0);
  assign in_ready_o = (count_q < CW'(DEPTH));
  assign push       = in_valid_i & in_ready_o;
  assign head_mul   = (ctrl_q[rd_ptr] == CTRL_MUL);
  assign settled    = !head_mul ||
                      (mul_cnt == MW'(MUL_LAT - 1));
  assign alu_valid_o = !empty && settled;
  assign pop        = alu_valid_o & alu_ready_i;
  assign count_o    = count_q;

  // When empty, show the last popped entry instead of
  // whatever stale slot rd_ptr happens to point at.
  assign ctrl_o = empty ? last_ctrl : ctrl_q[rd_ptr];
  assign src1_o = empty ? last_s1   : s1_q[rd_ptr];
  assign src2_o = empty ? last_s2   : s2_q[rd_ptr];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        ctrl_q[i] <= '0;
        s1_q[i]   <= '0;
        s2_q[i]   <= '0;
      end
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count_q   <= '0;
      mul_cnt   <= '0;
      last_ctrl <= '0;
      last_s1   <= '0;
      last_s2   <= '0;
      illegal_o <= 1'b0;
    end else begin
      illegal_o <= push & enc_ill;
      if (push) begin
        ctrl_q[wr_ptr] <= enc_ctrl;
        s1_q[wr_ptr]   <= src1_i;
        s2_q[wr_ptr]   <= src2_i;
        wr_ptr         <= wr_ptr + AW'(1);
      end
      if (pop) begin
        last_ctrl <= ctrl_q[rd_ptr];
        last_s1   <= s1_q[rd_ptr];
        last_s2   <= s2_q[rd_ptr];
        rd_ptr    <= rd_ptr + AW'(1);
      end
      unique case ({push, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
      // A new head appears after a pop or a push
      // into an empty FIFO; restart the settle timer.
      if (pop || (empty && push))
        mul_cnt <= '0;
      else if (!empty && !settled)
        mul_cnt <= mul_cnt + MW'(1);
    end
  end

endmodule

// File: tb/tb_alu_op_issue.sv
// Scoreboard bench for alu_op_issue.
// Random and directed ops checked against a queue model.
module tb_alu_op_issue;

  localparam int DEPTH   = 2;
  localparam int MUL_LAT = 3;

  logic        clk = 0;
  logic        rst = 1;
  logic        in_valid = 0;
  logic        in_ready;
  logic [2:0]  aluop = 0;
  logic [5:0]  funct = 0;
  logic [31:0] s1 = 0;
  logic [31:0] s2 = 0;
  logic        alu_valid;
  logic        alu_ready = 0;
  logic [3:0]  ctrl;
  logic [31:0] src1;
  logic [31:0] src2;
  logic        illegal;
  logic [1:0]  count;

  int n_cmp = 0;
  int n_bad = 0;
  bit rand_ready = 0;

  typedef struct {
    logic [3:0]  ctrl;
    logic [31:0] s1;
    logic [31:0] s2;
  } exp_t;

  exp_t q[$];
  exp_t last;
  int   age;
  bit   ill_exp;

  alu_op_issue #(
    .DATA_W(32), .DEPTH(DEPTH), .MUL_LAT(MUL_LAT)
  ) dut (
    .clk_i(clk), .rst_i(rst),
    .in_valid_i(in_valid), .in_ready_o(in_ready),
    .aluop_i(aluop), .funct_i(funct),
    .src1_i(s1), .src2_i(s2),
    .alu_valid_o(alu_valid), .alu_ready_i(alu_ready),
    .ctrl_o(ctrl), .src1_o(src1), .src2_o(src2),
    .illegal_o(illegal), .count_o(count)
  );

  always #5 clk = ~clk;

  task automatic chk(string name,
                     logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h @%0t",
               name, act, exp, $time);
    end
  endtask

  function automatic logic [3:0] ref_ctrl(
      logic [2:0] op, logic [5:0] fn);
    if (op == 3'b000) return 4'd2;
    if (op == 3'b001) return 4'd6;
    if (op == 3'b011) return 4'd7;
    if (op == 3'b100) return 4'd1;
    if (op == 3'b101) return 4'd0;
    if (op == 3'b010) begin
      case (fn)
        6'h20, 6'h21: return 4'd2;
        6'h22, 6'h23: return 4'd6;
        6'h24: return 4'd0;
        6'h25: return 4'd1;
        6'h27: return 4'd12;
        6'h2A: return 4'd7;
        6'h18: return 4'd3;
        default: return 4'd15;
      endcase
    end
    return 4'd15;
  endfunction

  // Model: q holds the FIFO contents of the current cycle;
  // age counts cycles the head has already spent at head.
  always @(negedge clk) begin
    bit mv;
    bit do_pop;
    bit do_push;
    exp_t e;
    if (rst) begin
      q.delete();
      age = 0;
      ill_exp = 0;
      last = '{4'd0, 32'd0, 32'd0};
    end else begin
      mv = (q.size() > 0) &&
           (q[0].ctrl != 4'd3 || age >= MUL_LAT - 1);
      chk("alu_valid", alu_valid, mv);
      chk("count", count, q.size());
      chk("in_ready", in_ready, q.size() < DEPTH);
      chk("illegal", illegal, ill_exp);
      if (q.size() > 0 && alu_valid) begin
        chk("ctrl", ctrl, q[0].ctrl);
        chk("src1", src1, q[0].s1);
        chk("src2", src2, q[0].s2);
      end else if (q.size() == 0) begin
        chk("hold_ctrl", ctrl, last.ctrl);
        chk("hold_src1", src1, last.s1);
        chk("hold_src2", src2, last.s2);
      end
      do_pop  = alu_valid && alu_ready;
      do_push = in_valid && in_ready;
      ill_exp = do_push && ref_ctrl(aluop, funct) == 4'd15;
      if (do_pop) begin
        last = q.pop_front();
        age = 0;
      end else if (q.size() > 0) begin
        age++;
      end
      if (do_push) begin
        if (q.size() == 0) age = 0;
        e.ctrl = ref_ctrl(aluop, funct);
        e.s1 = s1;
        e.s2 = s2;
        q.push_back(e);
      end
    end
  end

  always @(posedge clk) begin
    if (rand_ready) begin
      #1 alu_ready = ($urandom_range(0, 3) != 0);
    end
  end

  task automatic push(logic [2:0] op, logic [5:0] fn,
                      logic [31:0] a, logic [31:0] b);
    bit acc;
    int t;
    in_valid = 1;
    aluop = op;
    funct = fn;
    s1 = a;
    s2 = b;
    acc = 0;
    t = 0;
    while (!acc && t < 100) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      t++;
    end
    if (!acc) chk("push_timeout", 0, 1);
    in_valid = 0;
  endtask

  task automatic idle(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic rand_op(output logic [2:0] op,
                         output logic [5:0] fn,
                         input bit legal_nomul);
    logic [5:0] fl [8];
    fl = '{6'h20, 6'h21, 6'h22, 6'h23,
           6'h24, 6'h25, 6'h27, 6'h2A};
    if (legal_nomul) begin
      case ($urandom_range(0, 5))
        0: op = 3'b000;
        1: op = 3'b001;
        2: op = 3'b011;
        3: op = 3'b100;
        4: op = 3'b101;
        default: op = 3'b010;
      endcase
      fn = fl[$urandom_range(0, 7)];
    end else begin
      op = 3'($urandom_range(0, 7));
      case ($urandom_range(0, 2))
        0: fn = 6'h18;
        1: fn = fl[$urandom_range(0, 7)];
        default: fn = 6'($urandom);
      endcase
    end
  endtask

  initial begin
    logic [2:0] op;
    logic [5:0] fn;
    int t;
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [2:0] op;
    logic [5:0] fn;
    int t;
    idle(2);
    chk("rst_count", count, 0);
    chk("rst_valid", alu_valid, 0);
    chk("rst_ctrl", ctrl, 0);
    chk("rst_illegal", illegal, 0);
    rst = 0;
    #1;
    chk("rst_in_ready", in_ready, 1);
    idle(1);

    // Reset with two entries queued.
    alu_ready = 0;
    push(3'b000, 6'h00, 32'h11, 32'h22);
    push(3'b001, 6'h00, 32'h33, 32'h44);
    chk("pre_rst_count", count, 2);
    rst = 1;
    #1;
    chk("async_rst_count", count, 0);
    chk("async_rst_valid", alu_valid, 0);
    idle(2);
    rst = 0;
    idle(1);

    // NOR issued directly.
    alu_ready = 1;
    push(3'b010, 6'h27, 32'hF0, 32'h0F);
    idle(3);

    // Fill with ALU stalled; third op waits upstream.
    alu_ready = 0;
    push(3'b000, 6'h00, 32'hA1, 32'hB1);
    push(3'b011, 6'h00, 32'hA2, 32'hB2);
    fork
      push(3'b100, 6'h00, 32'hA3, 32'hB3);
      begin
        idle(5);
        alu_ready = 1;
      end
    join
    idle(4);

    // MUL settle.
    push(3'b010, 6'h18, 32'h7, 32'h9);
    idle(6);

    // Illegal then add.
    push(3'b111, 6'h00, 32'h5, 32'h6);
    push(3'b000, 6'h00, 32'h8, 32'h9);
    idle(4);

    // Streaming push+pop.
    for (int i = 0; i < 16; i++) begin
      rand_op(op, fn, 1);
      push(op, fn, $urandom, $urandom);
    end
    idle(3);

    // Random traffic with random backpressure.
    rand_ready = 1;
    for (int i = 0; i < 200; i++) begin
      rand_op(op, fn, 0);
      push(op, fn, $urandom, $urandom);
      if ($urandom_range(0, 3) == 0)
        idle($urandom_range(1, 4));
    end
    rand_ready = 0;
    #2;
    alu_ready = 1;
    t = 0;
    while (q.size() > 0 && t < 200) begin
      idle(1);
      t++;
    end
    chk("drain", q.size(), 0);
    idle(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
